term_write_ctrl: RTL and testbench

Sequences all writes into the 40x24 character frame memory of the video terminal.
- Accepts ASCII characters from the host over a valid/ready handshake.
- Tracks the cursor and handles CR, line wrap, hardware scroll (rotating top-row offset) and clear screen.
- Issues writes only in memory slots granted by the video timing chain, one write per slot.
- Sits between the host/PIA interface and the frame memory; scan-out reads top_row.

---
 rtl/term_write_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_term_write_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/term_write_ctrl.sv
// term_write_ctrl: sequences every write into the COLSxROWS character frame memory.
// Accepts host characters, tracks the cursor, handles CR, wrap, hardware scroll
// (rotating top_row) and clear-screen. Writes are issued only in granted wr_slot cycles.
//
// Ports:
//   clk, mr_n            clock, asynchronous active-low reset (reset blanks the screen)
//   char_in/char_valid   host character and its valid; char_ready = can accept
//   clr_req              clear-screen request (pulse or level)
//   wr_slot              frame memory write slot granted this cycle
//   mem_we/addr/wdata    frame memory write port (we only while wr_slot=1)
//   cur_col, cur_row     logical cursor position
//   top_row              physical row shown at the top of the screen
//   busy                 any operation in flight or clear pending
module term_write_ctrl #(
  parameter int unsigned COLS   = 40,
  parameter int unsigned ROWS   = 24,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              mr_n,
  input  logic [6:0]        char_in,
  input  logic              char_valid,
  output logic              char_ready,
  input  logic              clr_req,
  input  logic              wr_slot,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [5:0]        mem_wdata,
  output logic [5:0]        cur_col,
  output logic [4:0]        cur_row,
  output logic [4:0]        top_row,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StWrite, StClrLine, StClrAll} state_e;

  localparam logic [5:0]        RowsS   = 6'(ROWS);
  localparam logic [ADDR_W-1:0] ColsA   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LastA   = ADDR_W'(COLS * ROWS - 1);
  localparam logic [5:0]        LastCol = 6'(COLS - 1);
  localparam logic [4:0]        LastRow = 5'(ROWS - 1);
  localparam logic [5:0]        Space   = 6'h20;

  state_e            state_q;
  logic [5:0]        cur_col_q;
  logic [4:0]        cur_row_q;
  logic [4:0]        top_row_q;
  logic              clr_pend_q;
  logic [5:0]        clr_idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [5:0]        wdata_q;

  logic [5:0]        row_sum;
  logic [4:0]        phys_row;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] top_addr;
  logic [4:0]        top_next;
  logic              last_col;
  logic              last_row;
  logic              clr_any;
  logic              is_cr;
  logic              is_ctrl;

  // Physical row of the cursor, wrapped by a single subtraction (sum < 2*ROWS).
  always_comb begin
    row_sum  = {1'b0, top_row_q} + {1'b0, cur_row_q};
    phys_row = (row_sum >= RowsS) ? 5'(row_sum - RowsS) : row_sum[4:0];
    cur_addr = ADDR_W'(phys_row) * ColsA + ADDR_W'(cur_col_q);
    // On scroll the old top row becomes the new bottom row to blank.
    top_addr = ADDR_W'(top_row_q) * ColsA;
    top_next = (top_row_q == LastRow) ? 5'd0 : top_row_q + 5'd1;
    last_col = (cur_col_q == LastCol);
    last_row = (cur_row_q == LastRow);
    clr_any  = clr_pend_q | clr_req;
    is_cr    = (char_in == 7'h0D);
    is_ctrl  = (char_in[6:5] == 2'b00);
  end

  always_ff @(posedge clk or negedge mr_n) begin
    if (!mr_n) begin
      state_q    <= StClrAll;
      cur_col_q  <= '0;
      cur_row_q  <= '0;
      top_row_q  <= '0;
      clr_pend_q <= 1'b0;
      clr_idx_q  <= '0;
      addr_q     <= '0;
      wdata_q    <= Space;
    end else begin
      if (clr_req) clr_pend_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          // A pending or simultaneous clear beats any character on the same cycle.
          if (clr_any) begin
            state_q <= StClrAll;
            addr_q  <= '0;
            wdata_q <= Space;
          end else if (char_valid) begin
            if (is_cr) begin
              cur_col_q <= '0;
              if (!last_row) begin
                cur_row_q <= cur_row_q + 5'd1;
              end else begin
                top_row_q <= top_next;
                state_q   <= StClrLine;
                clr_idx_q <= '0;
                addr_q    <= top_addr;
                wdata_q   <= Space;
              end
            end else if (!is_ctrl) begin
              state_q <= StWrite;
              addr_q  <= cur_addr;
              wdata_q <= char_in[5:0];
            end
          end
        end
        StWrite: begin
          if (wr_slot) begin
            if (last_col) begin
              cur_col_q <= '0;
              if (!last_row) cur_row_q <= cur_row_q + 5'd1;
              else           top_row_q <= top_next;
            end else begin
              cur_col_q <= cur_col_q + 6'd1;
            end
            if (clr_any) begin
              state_q <= StClrAll;
              addr_q  <= '0;
              wdata_q <= Space;
            end else if (last_col && last_row) begin
              state_q   <= StClrLine;
              clr_idx_q <= '0;
              addr_q    <= top_addr;
              wdata_q   <= Space;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StClrLine: begin
          // A full clear supersedes the line blank in progress.
          if (clr_any) begin
            state_q <= StClrAll;
            addr_q  <= '0;
            wdata_q <= Space;
          end else if (wr_slot) begin
            if (clr_idx_q == LastCol) begin
              state_q <= StIdle;
            end else begin
              clr_idx_q <= clr_idx_q + 6'd1;
              addr_q    <= addr_q + ADDR_W'(1);
            end
          end
        end
        StClrAll: begin
          if (wr_slot) begin
            if (addr_q == LastA) begin
              state_q    <= StIdle;
              cur_col_q  <= '0;
              cur_row_q  <= '0;
              top_row_q  <= '0;
              clr_pend_q <= 1'b0;  // requests during the clear are absorbed
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
        end
      endcase
    end
  end

  // Gate with mr_n so no strobe leaks out while the reset state is CLR_ALL.
  assign mem_we     = wr_slot & mr_n & (state_q != StIdle);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign char_ready = (state_q == StIdle) & ~clr_pend_q;
  assign busy       = (state_q != StIdle) | clr_pend_q;
  assign cur_col    = cur_col_q;
  assign cur_row    = cur_row_q;
  assign top_row    = top_row_q;

endmodule

// File: tb/tb_term_write_ctrl.sv
// Bench for term_write_ctrl: directed table vectors, scroll/clear corner sequences,
// and a randomized run checked against a logical-screen model.
module tb_term_write_ctrl;

  localparam int COLS = 40;
  localparam int ROWS = 24;

  logic       clk = 1'b0;
  logic       mr_n = 1'b0;
  logic [6:0] char_in = '0;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic       clr_req = 1'b0;
  logic       wr_slot = 1'b0;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [5:0] mem_wdata;
  logic [5:0] cur_col;
  logic [4:0] cur_row;
  logic [4:0] top_row;
  logic       busy;

  term_write_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(10)) dut (
    .clk(clk), .mr_n(mr_n), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .clr_req(clr_req), .wr_slot(wr_slot), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cur_col(cur_col), .cur_row(cur_row),
    .top_row(top_row), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int viol   = 0;
  int mode   = 0;  // 0: slot always, 1: every 10th cycle, 2: random, 3: none
  int cyc    = 0;

  logic [9:0] laddr[$];
  logic [5:0] ldata[$];
  logic [5:0] tbmem[0:1023];

  // Reference model: logical screen rows 0..ROWS-1 as seen by the viewer.
  logic [5:0] scr[ROWS][COLS];
  int mcol, mrow, mtop;

  typedef struct {
    logic [6:0] ch;
    int rdy1;
    int col;
    int row;
    int nw;
    int addr;
    int data;
  } vec_t;
  vec_t tbl[8];

  always @(posedge clk) begin
    #2;
    cyc++;
    case (mode)
      0: wr_slot = 1'b1;
      1: wr_slot = (cyc % 10 == 0);
      2: wr_slot = 1'($urandom % 2);
      default: wr_slot = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (mem_we) begin
      if (!wr_slot) viol++;
      laddr.push_back(mem_addr);
      ldata.push_back(mem_wdata);
      tbmem[mem_addr] = mem_wdata;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) chk("idle_timeout", 0, 1);
  endtask

  task automatic send(input logic [6:0] ch);
    int n = 0;
    @(negedge clk);
    while (!char_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) chk("ready_timeout", 0, 1);
    char_in    = ch;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic do_reset(input int m);
    mode = 0;
    @(posedge clk);
    #2;
    mr_n       = 1'b0;
    clr_req    = 1'b0;
    char_valid = 1'b0;
    @(negedge clk);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_ready", int'(char_ready), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_cursor", int'(cur_col) + 64 * int'(cur_row) + 4096 * int'(top_row), 0);
    laddr.delete();
    ldata.delete();
    mode = m;
    @(posedge clk);
    #2;
    mr_n = 1'b1;
    @(negedge clk);
    wait_idle(20000);
  endtask

  // Checks that log entries [from, from+n) are a sequential run of spaces from a0.
  task automatic chk_run(input string nm, input int from, input int n, input int a0);
    int bad = 0;
    if (laddr.size() < from + n) begin
      chk({nm, "_len"}, laddr.size(), from + n);
    end else begin
      for (int i = 0; i < n; i++)
        if (int'(laddr[from+i]) != a0 + i || ldata[from+i] != 6'h20) bad++;
      chk(nm, bad, 0);
    end
  endtask

  task automatic chk_pos(input string nm, input int col, input int row, input int top);
    chk({nm, "_col"}, int'(cur_col), col);
    chk({nm, "_row"}, int'(cur_row), row);
    chk({nm, "_top"}, int'(top_row), top);
  endtask

  task automatic m_newline;
    mcol = 0;
    if (mrow < ROWS - 1) begin
      mrow++;
    end else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 6'h20;
      mtop = (mtop + 1) % ROWS;
    end
  endtask

  task automatic m_put(input logic [6:0] ch);
    if (ch == 7'h0D) begin
      m_newline();
    end else if (ch[6:5] != 2'b00) begin
      scr[mrow][mcol] = ch[5:0];
      if (mcol == COLS - 1) m_newline();
      else mcol++;
    end
  endtask

  task automatic m_clear;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 6'h20;
    mcol = 0;
    mrow = 0;
    mtop = 0;
  endtask

  task automatic chk_screen(input string nm);
    wait_idle(20000);
    for (int r = 0; r < ROWS; r++) begin
      int bad = 0;
      for (int c = 0; c < COLS; c++)
        if (tbmem[((mtop + r) % ROWS) * COLS + c] != scr[r][c]) bad++;
      chk($sformatf("%s_row%0d", nm, r), bad, 0);
    end
    chk_pos(nm, mcol, mrow, mtop);
  endtask

  // CRs down to the bottom row, one scrolling CR, then a printable at the new bottom.
  task automatic scroll_case(input string nm, input int ncr);
    for (int i = 0; i < ncr; i++) send(7'h0D);
    wait_idle(20000);
    chk_pos({nm, "_bottom"}, 0, ROWS - 1, 0);
    laddr.delete();
    ldata.delete();
    send(7'h0D);
    wait_idle(20000);
    chk_pos({nm, "_scroll"}, 0, ROWS - 1, 1);
    chk({nm, "_line_cnt"}, laddr.size(), COLS);
    chk_run({nm, "_line_seq"}, 0, COLS, 0);
    laddr.delete();
    ldata.delete();
    send(7'h42);
    wait_idle(20000);
    chk({nm, "_b_cnt"}, laddr.size(), 1);
    if (laddr.size() >= 1) begin
      chk({nm, "_b_addr"}, int'(laddr[0]), 0);
      chk({nm, "_b_data"}, int'(ldata[0]), 2);
    end
    chk_pos({nm, "_after_b"}, 1, ROWS - 1, 1);
  endtask

  initial begin
    int pre;
    int r;
    logic [6:0] ch;

    tbl[0] = '{7'h41, 0, 1, 0, 1, 0, 6'h01};
    tbl[1] = '{7'h07, 1, 1, 0, 0, -1, -1};
    tbl[2] = '{7'h0D, 1, 0, 1, 0, -1, -1};
    tbl[3] = '{7'h5A, 0, 1, 1, 1, 40, 6'h1A};
    tbl[4] = '{7'h20, 0, 2, 1, 1, 41, 6'h20};
    tbl[5] = '{7'h7E, 0, 3, 1, 1, 42, 6'h3E};
    tbl[6] = '{7'h00, 1, 3, 1, 0, -1, -1};
    tbl[7] = '{7'h0D, 1, 0, 2, 0, -1, -1};

    // Power-up clear with a slot every cycle.
    do_reset(0);
    chk("clr_cnt", laddr.size(), COLS * ROWS);
    chk_run("clr_seq", 0, COLS * ROWS, 0);
    chk("clr_ready", int'(char_ready), 1);
    chk_pos("clr_done", 0, 0, 0);

    // Single-character vectors.
    for (int i = 0; i < 8; i++) begin
      laddr.delete();
      ldata.delete();
      send(tbl[i].ch);
      chk($sformatf("v%0d_rdy1", i), int'(char_ready), tbl[i].rdy1);
      if (tbl[i].rdy1 == 0) begin
        @(negedge clk);
        chk($sformatf("v%0d_rdy2", i), int'(char_ready), 1);
      end
      wait_idle(1000);
      chk($sformatf("v%0d_col", i), int'(cur_col), tbl[i].col);
      chk($sformatf("v%0d_row", i), int'(cur_row), tbl[i].row);
      chk($sformatf("v%0d_nw", i), laddr.size(), tbl[i].nw);
      if (tbl[i].nw > 0 && laddr.size() > 0) begin
        chk($sformatf("v%0d_addr", i), int'(laddr[0]), tbl[i].addr);
        chk($sformatf("v%0d_data", i), int'(ldata[0]), tbl[i].data);
      end
    end

    // Line wrap after 40 printables, then CR.
    do_reset(0);
    laddr.delete();
    ldata.delete();
    for (int i = 0; i < COLS; i++) send(7'(7'h41 + i % 26));
    wait_idle(1000);
    chk("wrap_cnt", laddr.size(), COLS);
    if (laddr.size() == COLS) chk("wrap_last_addr", int'(laddr[COLS-1]), COLS - 1);
    chk_pos("wrap", 0, 1, 0);
    laddr.delete();
    ldata.delete();
    send(7'h0D);
    wait_idle(1000);
    chk("cr_no_write", laddr.size(), 0);
    chk_pos("cr", 0, 2, 0);

    scroll_case("scroll", ROWS - 3);

    // Same scroll with a slot only every 10th cycle.
    do_reset(0);
    mode = 1;
    scroll_case("sparse", ROWS - 1);
    chk("sparse_we_wo_slot", viol, 0);

    // Clear request in the middle of a line blank.
    do_reset(0);
    mode = 1;
    for (int i = 0; i < ROWS - 1; i++) send(7'h0D);
    wait_idle(1000);
    laddr.delete();
    ldata.delete();
    send(7'h0D);
    repeat (55) @(negedge clk);
    chk("mid_line_busy", int'(busy), 1);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    mode = 0;
    wait_idle(20000);
    pre = laddr.size() - COLS * ROWS;
    chk("abandon_partial", int'(pre >= 0 && pre < COLS), 1);
    if (pre >= 0) chk_run("abandon_clr_seq", pre, COLS * ROWS, 0);
    chk_pos("abandon", 0, 0, 0);

    // Clear and character on the same idle cycle: clear wins.
    send(7'h41);
    wait_idle(1000);
    chk_pos("pre_tie", 1, 0, 0);
    laddr.delete();
    ldata.delete();
    @(negedge clk);
    clr_req    = 1'b1;
    char_valid = 1'b1;
    char_in    = 7'h43;
    @(negedge clk);
    clr_req    = 1'b0;
    char_valid = 1'b0;
    wait_idle(20000);
    chk("tie_cnt", laddr.size(), COLS * ROWS);
    chk_run("tie_seq", 0, COLS * ROWS, 0);
    chk_pos("tie", 0, 0, 0);

    // Randomized traffic with random slots against the screen model.
    do_reset(2);
    m_clear();
    for (int i = 0; i < 320; i++) begin
      r = int'($urandom % 100);
      if (r < 2) begin
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        m_clear();
      end else begin
        if (r < 18) ch = 7'h0D;
        else if (r < 25) begin
          ch = 7'($urandom % 32);
          if (ch == 7'h0D) ch = 7'h0A;
        end else ch = 7'(32 + $urandom % 96);
        send(ch);
        m_put(ch);
      end
      if (i == 160) chk_screen("rnd_mid");
    end
    chk_screen("rnd_end");
    chk("rnd_we_wo_slot", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
